// File: rtl/mul_ctrl_pkg.sv
// Shared widths, defaults and state encoding for the mul_ctrl operand sequencer.
package mul_ctrl_pkg;

   localparam int unsigned MUL_W       = 8;
   localparam int unsigned RES_W       = 17;
   localparam int unsigned ACC_W       = 24;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_TIMEOUT = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

endpackage

// File: rtl/mul_ctrl_fifo.sv
// Operand-pair FIFO: DEPTH entries, head always visible, async active-low reset on pointers.
module mul_ctrl_fifo
   import mul_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned WIDTH = 2 * MUL_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit separates the full and empty cases when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer in front of the shift-add multiplier: operand FIFO, launch/capture FSM, timeout flag.
// Optional running accumulator of products when MUL_CTRL_ACC_EN is defined.
module mul_ctrl
   import mul_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [MUL_W-1:0] inA,
   input  logic [MUL_W-1:0] inB,
   output logic [MUL_W-1:0] mulA,
   output logic [MUL_W-1:0] mulB,
   output logic             mulStart,
   input  logic [RES_W-1:0] mulResult,
   input  logic             mulFinish,
   output logic             outValid,
   input  logic             outReady,
   output logic [RES_W-1:0] outData,
`ifdef MUL_CTRL_ACC_EN
   input  logic             accClear,
   output logic [ACC_W-1:0] accSum,
`endif
   output logic             error
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_t             state;
   state_t             state_nxt;
   logic [CW-1:0]      cnt;
   logic               push;
   logic               full;
   logic               empty;
   logic               capture;
   logic               timeout_hit;
   logic [2*MUL_W-1:0] head;

   assign inReady = !full;
   assign push    = inValid && !full;

   mul_ctrl_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * MUL_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (capture),
      .din     ({inA, inB}),
      .full    (full),
      .empty   (empty),
      .head    (head)
   );

   assign mulA = head[2*MUL_W-1:MUL_W];
   assign mulB = head[MUL_W-1:0];

   // Derived from the async-reset state register, so it rises immediately on reset.
   assign mulStart = (state != RUN);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && (!outValid || outReady) && !error)
               state_nxt = RUN;
         end
         RUN: begin
            if (mulFinish) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = ERR;
            end
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         outValid <= 1'b0;
         outData  <= '0;
         error    <= 1'b0;
      end else begin
         cnt <= (state == RUN && state_nxt == RUN) ? cnt + 1'b1 : '0;
         if (capture) begin
            outValid <= 1'b1;
            outData  <= mulResult;
         end else if (outValid && outReady) begin
            outValid <= 1'b0;
         end
         if (timeout_hit)
            error <= 1'b1;
      end
   end

`ifdef MUL_CTRL_ACC_EN
   // A clear coinciding with a capture restarts the sum at that product.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         accSum <= '0;
      else if (accClear)
         accSum <= capture ? ACC_W'(mulResult) : '0;
      else if (capture)
         accSum <= accSum + ACC_W'(mulResult);
   end
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed self-checking bench for mul_ctrl with a behavioural 8-step multiplier alongside.
module tb_mul_ctrl;
   import mul_ctrl_pkg::*;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [MUL_W-1:0] inA = '0;
   logic [MUL_W-1:0] inB = '0;
   logic [MUL_W-1:0] mulA;
   logic [MUL_W-1:0] mulB;
   logic             mulStart;
   logic [RES_W-1:0] mulResult;
   logic             mulFinish;
   logic             outValid;
   logic             outReady = 1'b0;
   logic [RES_W-1:0] outData;
   logic             error;
`ifdef MUL_CTRL_ACC_EN
   logic             accClear = 1'b0;
   logic [ACC_W-1:0] accSum;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   mul_ctrl #(
      .DEPTH   (4),
      .TIMEOUT (12)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .inValid   (inValid),
      .inReady   (inReady),
      .inA       (inA),
      .inB       (inB),
      .mulA      (mulA),
      .mulB      (mulB),
      .mulStart  (mulStart),
      .mulResult (mulResult),
      .mulFinish (mulFinish),
      .outValid  (outValid),
      .outReady  (outReady),
      .outData   (outData),
`ifdef MUL_CTRL_ACC_EN
      .accClear  (accClear),
      .accSum    (accSum),
`endif
      .error     (error)
   );

   // Multiplier model: cleared while start=1, steps 8 times, finish in the 9th cycle.
   logic [3:0] mcnt = '0;
   logic       stall = 1'b0;
   always @(posedge clock) begin
      if (mulStart)
         mcnt <= '0;
      else if (mcnt != 4'd8)
         mcnt <= mcnt + 4'd1;
   end
   assign mulFinish = !mulStart && (mcnt == 4'd8) && !stall;
   assign mulResult = (mcnt == 4'd8) ? 17'({9'd0, mulA} * {9'd0, mulB}) : 17'h1ABCD;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_pair(input logic [7:0] a, input logic [7:0] b,
                           input logic [31:0] exp, input string tag);
      int lat;
      inA      = a;
      inB      = b;
      inValid  = 1'b1;
      outReady = 1'b1;
      tick();
      inValid = 1'b0;
      lat = 0;
      while (!outValid && lat < 30) begin
         tick();
         lat++;
      end
      chk({tag, " latency"}, lat, 10);
      chk({tag, " data"}, outData, exp);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int acc_cnt;
   int nres;
   int t;
   int rdata [5];
   int rtime [5];
   int exp_d [5] = '{2, 12, 30, 56, 90};

   initial begin
      // Reset values
      #2;
      chk("rst mulStart", mulStart, 1);
      chk("rst outValid", outValid, 0);
      chk("rst outData", outData, 0);
      chk("rst error", error, 0);
      chk("rst inReady", inReady, 1);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Single pair 3*5, mulStart low exactly P+1..P+9
      inA = 8'd3;
      inB = 8'd5;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      chk("t1 start at P", mulStart, 1);
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("t1 start low", mulStart, 0);
         chk("t1 outValid low", outValid, 0);
         if (k == 1) begin
            chk("t1 mulA", mulA, 3);
            chk("t1 mulB", mulB, 5);
         end
      end
      tick();
      chk("t1 outValid", outValid, 1);
      chk("t1 outData", outData, 15);
      chk("t1 start back", mulStart, 1);
      outReady = 1'b1;
      tick();
      chk("t1 consumed", outValid, 0);

      // Operand extremes
      run_pair(8'd255, 8'd255, 65025, "max");
      run_pair(8'd0, 8'd200, 0, "zero");

      // Backpressure: five offers with the output stalled
      outReady = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         inA = 8'(2 * i + 1);
         inB = 8'(2 * i + 2);
         inValid = 1'b1;
         if (inReady)
            acc_cnt++;
         tick();
      end
      inValid = 1'b0;
      chk("bp accepted", acc_cnt, 4);
      chk("bp inReady full", inReady, 0);
      repeat (12) tick();
      chk("bp held valid", outValid, 1);
      chk("bp held data", outData, 2);
      chk("bp slot freed", inReady, 1);
      chk("bp no launch", mulStart, 1);
      inA = 8'd9;
      inB = 8'd10;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      chk("bp refull", inReady, 0);
      outReady = 1'b1;
      nres = 0;
      t = 0;
      while (nres < 5 && t < 80) begin
         if (outValid) begin
            rdata[nres] = outData;
            rtime[nres] = t;
            nres++;
         end
         tick();
         t++;
      end
      chk("bp result count", nres, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < nres) begin
            chk("bp order", rdata[i], exp_d[i]);
            if (i > 0)
               chk("bp spacing", rtime[i] - rtime[i-1], 10);
         end
      end

      // Async reset mid-RUN discards the in-flight product
      run_pair(8'd2, 8'd3, 6, "pre-reset");
      inA = 8'd4;
      inB = 8'd4;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      tick();
      repeat (4) tick();
      chk("rr running", mulStart, 0);
      reset_n = 1'b0;
      #1;
      chk("rr mulStart", mulStart, 1);
      chk("rr outValid", outValid, 0);
      chk("rr outData", outData, 0);
      chk("rr error", error, 0);
      chk("rr inReady", inReady, 1);
      #2;
      reset_n = 1'b1;
      run_pair(8'd9, 8'd11, 99, "post-reset");

      // Stalled multiplier trips the timeout
      stall = 1'b1;
      inA = 8'd6;
      inB = 8'd7;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      tick();
      chk("to launched", mulStart, 0);
      repeat (11) tick();
      chk("to error not yet", error, 0);
      chk("to still run", mulStart, 0);
      tick();
      chk("to error set", error, 1);
      chk("to start high", mulStart, 1);
      chk("to no outValid", outValid, 0);
      stall = 1'b0;
      repeat (5) tick();
      chk("to error sticky", error, 1);
      chk("to start stays", mulStart, 1);
      chk("to no outValid later", outValid, 0);

`ifdef MUL_CTRL_ACC_EN
      reset_n = 1'b0;
      #2;
      chk("acc reset", accSum, 0);
      reset_n = 1'b1;
      tick();
      run_pair(8'd3, 8'd5, 15, "acc1");
      run_pair(8'd10, 8'd10, 100, "acc2");
      run_pair(8'd255, 8'd255, 65025, "acc3");
      chk("acc sum", accSum, 65140);
      accClear = 1'b1;
      tick();
      accClear = 1'b0;
      chk("acc clear", accSum, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Operand sequencer and result collector placed directly in front of the 8×8 shift-add multiplier `mul`. Accepts operand pairs over a valid/ready stream into a 4-entry FIFO and drives `mul`'s `A`/`B`/`start`. Detects `finish`, captures the 17-bit product into a registered valid/ready output, and flags a multiplier that never finishes.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries (power of two, ≥2).
- `TIMEOUT`, 12: cycles in RUN without `mulFinish` before `error` is set.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `inValid`  in  1  operand pair offered.
- `inReady`  out  1  FIFO not full.
- `inA`, `inB`  in  8 each  operands.
- `mulA`, `mulB`  out  8 each  to `mul.A`, `mul.B`.
- `mulStart`  out  1  to `mul.start`.
- `mulResult`  in  17  from `mul.result`.
- `mulFinish`  in  1  from `mul.finish`.
- `outValid`  out  1  product held.
- `outReady`  in  1  consumer accepts.
- `outData`  out  17  product.
- `error`  out  1  sticky timeout flag.

## Operation
- Reset values: `mulStart`=1, `outValid`=0, `outData`=0, `error`=0, FIFO empty, state IDLE, timeout counter 0. `inReady` is combinational (!full), so it is 1 after reset.
- `mulStart` is held at 1 whenever the block is not in RUN. This keeps `mul` cleared, because `mul` has no reset of its own.
- `mulA`/`mulB` are driven from the FIFO head at all times. Head is stable for the whole of RUN.
- FIFO push: `inValid && inReady`. Pop: only at the RUN→IDLE capture edge. No pop occurs while the FIFO is empty.
- States:
  - IDLE → RUN when FIFO is non-empty, `outValid`=0 (or `outValid && outReady` this cycle), and `error`=0.
  - RUN (`mulStart`=0): counter increments each cycle.
  - RUN → IDLE when `mulFinish`=1. On that edge: `outData`←`mulResult`, `outValid`←1, pop FIFO, counter←0.
  - RUN → ERR when the counter reaches `TIMEOUT` without `mulFinish`. On that edge `error`←1 and `mulStart`←1.
  - ERR is terminal until `reset_n` is asserted. The FIFO entry is not popped.
- Output handshake: `outValid` clears on `outValid && outReady` unless a capture happens on the same edge. That cannot occur, because launch requires the output register to be free.
- `mulFinish` seen outside RUN is ignored.
- Width: `outData` is the 17-bit `mulResult` unmodified. No truncation.

## Timing
- Launch edge: IDLE→RUN; `mulStart` falls in cycle L. `mul` steps on edges L…L+7.
- `mulFinish` is high during cycle L+8. Capture happens at the end of L+8.
- `outValid` is high from cycle L+9.
- Back-to-back: the next launch edge can be the same edge on which the previous output is consumed. Minimum 10 cycles per product.
- Input-to-output latency with FIFO empty and `outReady`=1: push at edge P, launch edge P+1, `outValid` at cycle P+10.
- Full FIFO: `inReady`=0. A simultaneous pop frees the slot next cycle, not the same cycle.
- Async reset mid-RUN: all state is cleared immediately and `mulStart` goes to 1 asynchronously. The in-flight product is discarded.

## Configuration
- `MUL_CTRL_ACC_EN` defined:
  - Adds output `accSum` (24 bits, reset 0) and input `accClear` (1 bit).
  - Every capture edge adds `mulResult` to `accSum`, wrapping modulo 2^24.
  - `accClear`=1 zeroes `accSum`. If `accClear`=1 on a capture edge, `accSum`←`mulResult`.
- Undefined: neither port exists and there is no accumulator logic. All other behaviour is identical.

## Structure
- Package `mul_ctrl_pkg`:
  - state encoding IDLE/RUN/ERR
  - `MUL_W`=8
  - `RES_W`=17
  - `ACC_W`=24
  - default `DEPTH`/`TIMEOUT`
- Sub-module `mul_ctrl_fifo`: `DEPTH`×16-bit synchronous FIFO with push/pop/full/empty/head and async active-low reset.
- `mul` is instantiated alongside in the enclosing level, not inside this block.

## Test plan
- Single pair: push A=3, B=5 at edge P → `outValid`=1 at cycle P+10 with `outData`=15; `mulStart` low for exactly cycles P+1…P+9.
- Max operands: A=255, B=255 → `outData`=65025; operand 0×200 → `outData`=0.
- Backpressure: push 5 pairs with `outReady`=0 → `inReady` drops after 4 accepted and the first result is held. Release `outReady` → results come out in order, at ≥10-cycle spacing.
- Stalled multiplier: tie `mulFinish`=0 → `error`=1 after 12 RUN cycles, `mulStart`=1, and no `outValid`.
- Reset during RUN at cycle L+4 → all outputs return to reset values that cycle. After release, a fresh pair produces the correct product.
- With `MUL_CTRL_ACC_EN`: products 15, 100, 65025 → `accSum`=65140. Pulse `accClear` → 0.
